jzjpcc_memory_data_controller: RTL and testbench

Memory-stage data-side controller sitting between the execute/memory pipeline stages and port B of the inferred SRAM plus the 8+8 MMIO word registers. It decodes each data access into RAM, MMIO or unmapped regions. It drives SRAM port B and owns the byte-maskable MMIO output registers. It registers the region select so read data lines up with the SRAM's one-cycle read latency, and records the first unmapped write in a sticky fault register.

---
 rtl/jzjpcc_memory_data_controller.sv | 141 ++++++++++++++
 tb/tb_jzjpcc_memory_data_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_memory_data_controller.sv
// Memory-stage data-side controller: decodes accesses into RAM / MMIO / unmapped regions,
// drives SRAM port B, owns the MMIO output words and the sticky unmapped-write fault.
module jzjpcc_memory_data_controller #(
    parameter int          RAM_A_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFFFFC0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   memWriteEnable,
    input  logic [31:2]            memAddress,
    input  logic [31:0]            memDataToWrite,
    input  logic [3:0]             memByteMask,
    output logic [31:0]            memDataRead,
    output logic [RAM_A_WIDTH-1:0] ramAddressB,
    output logic                   ramWriteEnableB,
    output logic [3:0]             ramByteWriteMaskB,
    output logic [31:0]            ramWriteDataB,
    input  logic [31:0]            ramReadDataB,
    input  logic [31:0]            mmioInputs [8],
    output logic [31:0]            mmioOutputs [8],
    input  logic                   clearFault,
    output logic                   accessFault,
    output logic [31:2]            faultAddress
);

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_MMIO_IN  = 2'd1,
        REGION_MMIO_OUT = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_t;

    region_t     decodeRegion;
    logic [2:0]  decodeIdx;
    logic        isRam;
    logic        isMmio;
    logic        mmioWrite;
    logic        newFault;

    region_t     regionQ;
    logic [31:0] inQ;
    logic [31:0] outQ;

    // Address decode of the execute-stage access; RAM wins if the windows ever overlap.
    always_comb begin
        isRam        = (memAddress[31:RAM_A_WIDTH+2] == {(30-RAM_A_WIDTH){1'b0}});
        isMmio       = (memAddress[31:6] == MMIO_BASE[31:6]);
        decodeIdx    = memAddress[4:2];
        decodeRegion = REGION_UNMAPPED;
        if (isRam) begin
            decodeRegion = REGION_RAM;
        end else if (isMmio) begin
            if (memAddress[5]) begin
                decodeRegion = REGION_MMIO_OUT;
            end else begin
                decodeRegion = REGION_MMIO_IN;
            end
        end else begin
            decodeRegion = REGION_UNMAPPED;
        end
    end

    // SRAM port B is driven straight from the execute stage so the SRAM's own
    // read register supplies the one-cycle latency.
    always_comb begin
        ramAddressB       = memAddress[RAM_A_WIDTH+1:2];
        ramWriteDataB     = memDataToWrite;
        ramWriteEnableB   = memWriteEnable & (decodeRegion == REGION_RAM) & ~reset;
        ramByteWriteMaskB = 4'b0000;
        if (decodeRegion == REGION_RAM) begin
            ramByteWriteMaskB = memByteMask;
        end else begin
            ramByteWriteMaskB = 4'b0000;
        end
    end

    // Write qualifiers for the MMIO output words and the fault tracker.
    always_comb begin
        mmioWrite = memWriteEnable & (decodeRegion == REGION_MMIO_OUT);
        newFault  = memWriteEnable & (decodeRegion == REGION_UNMAPPED) & (memByteMask != 4'b0000);
    end

    // Region register plus sampled MMIO words; sampling the word itself at the
    // edge stands in for a registered index and gives read-old on MMIO_OUT.
    always_ff @(posedge clock) begin
        if (reset) begin
            regionQ <= REGION_UNMAPPED;
            inQ     <= 32'h0000_0000;
            outQ    <= 32'h0000_0000;
        end else begin
            regionQ <= decodeRegion;
            inQ     <= mmioInputs[decodeIdx];
            outQ    <= mmioOutputs[decodeIdx];
        end
    end

    // Memory-stage read mux over the registered region.
    always_comb begin
        memDataRead = 32'h0000_0000;
        case (regionQ)
            REGION_RAM:      memDataRead = ramReadDataB;
            REGION_MMIO_IN:  memDataRead = inQ;
            REGION_MMIO_OUT: memDataRead = outQ;
            REGION_UNMAPPED: memDataRead = 32'h0000_0000;
            default:         memDataRead = 32'h0000_0000;
        endcase
    end

    // Byte-maskable MMIO output registers; writes to the input words are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mmioOutputs[i] <= 32'h0000_0000;
            end
        end else if (mmioWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (memByteMask[k]) begin
                    mmioOutputs[decodeIdx][8*k +: 8] <= memDataToWrite[8*k +: 8];
                end
            end
        end
    end

    // Sticky fault: a new fault beats a same-cycle clear and recaptures the address.
    always_ff @(posedge clock) begin
        if (reset) begin
            accessFault  <= 1'b0;
            faultAddress <= 30'h0000_0000;
        end else if (newFault) begin
            accessFault <= 1'b1;
            if (~accessFault | clearFault) begin
                faultAddress <= memAddress;
            end
        end else if (clearFault) begin
            accessFault <= 1'b0;
        end else begin
            accessFault <= accessFault;
        end
    end

endmodule

// File: tb/tb_jzjpcc_memory_data_controller.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor pops and compares.
module tb_jzjpcc_memory_data_controller;

    localparam int          RAM_A_WIDTH = 12;
    localparam logic [31:0] MMIO_BASE   = 32'hFFFFFFC0;
    localparam int          RAM_WORDS   = 1 << RAM_A_WIDTH;

    logic                   clock          = 1'b0;
    logic                   reset          = 1'b1;
    logic                   memWriteEnable = 1'b0;
    logic [31:0]            memAddrByte    = 32'h0;
    logic [31:2]            memAddress;
    logic [31:0]            memDataToWrite = 32'h0;
    logic [3:0]             memByteMask    = 4'h0;
    logic [31:0]            memDataRead;
    logic [RAM_A_WIDTH-1:0] ramAddressB;
    logic                   ramWriteEnableB;
    logic [3:0]             ramByteWriteMaskB;
    logic [31:0]            ramWriteDataB;
    logic [31:0]            ramReadDataB = 32'h0;
    logic [31:0]            mmioInputs [8] = '{default: 32'h0};
    logic [31:0]            mmioOutputs [8];
    logic                   clearFault = 1'b0;
    logic                   accessFault;
    logic [31:2]            faultAddress;

    assign memAddress = memAddrByte[31:2];

    jzjpcc_memory_data_controller #(
        .RAM_A_WIDTH(RAM_A_WIDTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .memWriteEnable   (memWriteEnable),
        .memAddress       (memAddress),
        .memDataToWrite   (memDataToWrite),
        .memByteMask      (memByteMask),
        .memDataRead      (memDataRead),
        .ramAddressB      (ramAddressB),
        .ramWriteEnableB  (ramWriteEnableB),
        .ramByteWriteMaskB(ramByteWriteMaskB),
        .ramWriteDataB    (ramWriteDataB),
        .ramReadDataB     (ramReadDataB),
        .mmioInputs       (mmioInputs),
        .mmioOutputs      (mmioOutputs),
        .clearFault       (clearFault),
        .accessFault      (accessFault),
        .faultAddress     (faultAddress)
    );

    always #5 clock = ~clock;

    int cycleCount = 0;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Environment SRAM with registered read-old port B.
    logic [31:0] envRam [RAM_WORDS] = '{default: 32'h0};
    always @(posedge clock) begin
        ramReadDataB <= envRam[ramAddressB];
        if (ramWriteEnableB) begin
            for (int k = 0; k < 4; k++) begin
                if (ramByteWriteMaskB[k]) envRam[ramAddressB][8*k +: 8] <= ramWriteDataB[8*k +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] modelRam [RAM_WORDS] = '{default: 32'h0};
    logic [31:0] modelOut [8] = '{default: 32'h0};
    logic        modelFault = 1'b0;
    logic [29:0] modelFaultAddr = 30'h0;
    logic [31:0] nextInputs [8] = '{default: 32'h0};

    typedef struct packed {
        int              due;
        logic [31:0]     rd;
        logic            flt;
        logic [29:0]     fa;
        logic [7:0][31:0] outs;
    } readExp_t;

    typedef struct packed {
        int          due;
        logic        we;
        logic [RAM_A_WIDTH-1:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } portExp_t;

    readExp_t readQ[$];
    portExp_t portQ[$];

    int  nChecks = 0;
    int  nFails  = 0;
    logic done = 1'b0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldV, input logic [31:0] newV,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = oldV;
        for (int k = 0; k < 4; k++) if (mask[k]) r[8*k +: 8] = newV[8*k +: 8];
        return r;
    endfunction

    // One access: drive inputs 2 time units after the edge, model it, queue expectations.
    task automatic step(input logic r, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input logic clr);
        readExp_t re;
        portExp_t pe;
        logic inRam, inMmio;
        logic [31:0] off;
        int w, word;
        @(posedge clock);
        #2;
        reset = r; memWriteEnable = we; memAddrByte = addr;
        memDataToWrite = data; memByteMask = mask; clearFault = clr;
        for (int i = 0; i < 8; i++) mmioInputs[i] = nextInputs[i];

        inRam  = addr < 32'(4 * RAM_WORDS);
        off    = addr - MMIO_BASE;
        inMmio = !inRam && (off < 32'd64);
        w      = int'(off >> 2);
        word   = int'(addr >> 2) % RAM_WORDS;

        pe.due  = cycleCount;
        pe.we   = we && inRam && !r;
        pe.addr = RAM_A_WIDTH'(addr >> 2);
        pe.mask = inRam ? mask : 4'h0;
        pe.data = data;
        portQ.push_back(pe);

        if (r)               re.rd = 32'h0;
        else if (inRam)      re.rd = modelRam[word];
        else if (inMmio)     re.rd = (w < 8) ? nextInputs[w] : modelOut[w-8];
        else                 re.rd = 32'h0;

        if (r) begin
            for (int i = 0; i < 8; i++) modelOut[i] = 32'h0;
            modelFault = 1'b0;
            modelFaultAddr = 30'h0;
        end else begin
            if (we && inRam) modelRam[word] = mergeBytes(modelRam[word], data, mask);
            if (we && inMmio && w >= 8) modelOut[w-8] = mergeBytes(modelOut[w-8], data, mask);
            if (we && !inRam && !inMmio && mask != 4'h0) begin
                if (!modelFault || clr) modelFaultAddr = addr[31:2];
                modelFault = 1'b1;
            end else if (clr) begin
                modelFault = 1'b0;
            end
        end

        re.due = cycleCount + 1;
        re.flt = modelFault;
        re.fa  = modelFaultAddr;
        for (int i = 0; i < 8; i++) re.outs[i] = modelOut[i];
        readQ.push_back(re);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycleCount, act, exp);
        end
    endtask

    // Monitor: compares every output that has come due at this falling edge.
    readExp_t mRe;
    portExp_t mPe;
    int drain = 0;
    always @(negedge clock) begin
        while (portQ.size() > 0 && portQ[0].due <= cycleCount) begin
            mPe = portQ.pop_front();
            check("portTiming", 64'(cycleCount), 64'(mPe.due));
            check("ramWriteEnableB", 64'(ramWriteEnableB), 64'(mPe.we));
            check("ramAddressB", 64'(ramAddressB), 64'(mPe.addr));
            check("ramByteWriteMaskB", 64'(ramByteWriteMaskB), 64'(mPe.mask));
            check("ramWriteDataB", 64'(ramWriteDataB), 64'(mPe.data));
        end
        while (readQ.size() > 0 && readQ[0].due <= cycleCount) begin
            mRe = readQ.pop_front();
            check("readTiming", 64'(cycleCount), 64'(mRe.due));
            check("memDataRead", 64'(memDataRead), 64'(mRe.rd));
            check("accessFault", 64'(accessFault), 64'(mRe.flt));
            check("faultAddress", 64'(faultAddress), 64'(mRe.fa));
            for (int i = 0; i < 8; i++) check("mmioOutputs", 64'(mmioOutputs[i]), 64'(mRe.outs[i]));
        end
        if (done) begin
            drain++;
            if (drain == 4) begin
                check("queueDrain", 64'(readQ.size() + portQ.size()), 64'h0);
                $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
                $finish;
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] a;
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        // RAM write then read
        step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 32'h10, 32'h01020304, 4'b1001, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        // MMIO output partial write, back-to-back readback
        step(1'b0, 1'b1, MMIO_BASE + 32'h20, 32'h11223344, 4'b0101, 1'b0);
        step(1'b0, 1'b0, MMIO_BASE + 32'h20, 32'h0, 4'h0, 1'b0);
        // MMIO input sampling and hold
        nextInputs[3] = 32'hCAFEF00D;
        step(1'b0, 1'b0, MMIO_BASE + 32'h0C, 32'h0, 4'h0, 1'b0);
        nextInputs[3] = 32'h12345678;
        step(1'b0, 1'b1, MMIO_BASE + 32'h0C, 32'hFFFFFFFF, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        // Faults: first captured, second ignored, clear+new recaptures, then clear
        step(1'b0, 1'b1, 32'h80000000, 32'h0, 4'hF, 1'b0);
        step(1'b0, 1'b1, 32'h80000010, 32'h0, 4'hF, 1'b0);
        step(1'b0, 1'b1, 32'h80000040, 32'h0, 4'h1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        // Writes under reset are ignored
        step(1'b0, 1'b1, MMIO_BASE + 32'h3C, 32'hAAAA5555, 4'hF, 1'b0);
        step(1'b0, 1'b1, 32'h80000000, 32'h0, 4'hF, 1'b0);
        step(1'b1, 1'b1, MMIO_BASE + 32'h3C, 32'hFFFFFFFF, 4'hF, 1'b0);
        step(1'b1, 1'b1, 32'h20, 32'h55555555, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        // Zero-mask writes never fault and change nothing
        step(1'b0, 1'b1, MMIO_BASE + 32'h24, 32'h0BADCAFE, 4'hF, 1'b0);
        step(1'b0, 1'b1, 32'h90000000, 32'h12345678, 4'h0, 1'b0);
        step(1'b0, 1'b1, MMIO_BASE + 32'h24, 32'hFFFFFFFF, 4'h0, 1'b0);
        step(1'b0, 1'b0, MMIO_BASE + 32'h24, 32'h0, 4'h0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) nextInputs[i] = $urandom();
            case ($urandom_range(0, 3))
                0:       a = 32'(4 * $urandom_range(0, 31));
                1:       a = 32'(4 * $urandom_range(0, RAM_WORDS - 1));
                2:       a = MMIO_BASE + 32'(4 * $urandom_range(0, 15));
                default: a = $urandom();
            endcase
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), a, $urandom(),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        done = 1'b1;
    end

endmodule
